hilo_commit_m: RTL and testbench
================================

// Module: hilo_commit_m
// PURPOSE
//  Memory-stage (M) consumer of the 64-bit EX result. Registers the EX result
//  into the M pipeline slot and owns the architectural HI/LO pair.
//  Commits mult/div/mthi/mtlo results to HI/LO only when the instruction leaves
//  M without an exception. Forwards the youngest HI/LO value back to EX.
// PARAMETERS
//  DW        32      width of one half (HI or LO)
//  HILO_RST  64'h0   reset value of {HI,LO}
// PORTS
//  clk               in   1     clock, rising edge
//  rst               in   1     asynchronous reset, active-low (0 = reset)
//  stallM            in   1     hold M slot; no commit this cycle
//  flushM            in   1     insert bubble into M (E instruction dropped)
//  flush_exceptionM  in   1     instruction in M faulted: kill its commit
//  validE            in   1     E slot holds a real instruction
//  hilo_wenE         in   1     E instruction writes HI/LO (mult, div, mthi, mtlo)
//  alu_outE          in   2*DW  EX result; {HI,LO} image when hilo_wenE=1
//  alu_outM          out  2*DW  registered EX result in M slot
//  validM            out  1     M slot holds a real instruction
//  hilo_wenM         out  1     M instruction writes HI/LO
//  hiloE             out  2*DW  {HI,LO} as seen by the instruction in E (forwarded)
//  hi_o, lo_o        out  DW    committed architectural HI, LO
// BEHAVIOUR
//  Reset (rst=0, async): alu_outM=0, validM=0, hilo_wenM=0, {HI,LO}=HILO_RST.
//  M slot update, per rising edge, priority high->low:
//   1 flush_exceptionM=1 -> validM<=0, hilo_wenM<=0 (even if stallM=1)
//   2 stallM=1           -> hold alu_outM, validM, hilo_wenM
//   3 flushM=1           -> validM<=0, hilo_wenM<=0; alu_outM<=0
//   4 else               -> alu_outM<=alu_outE; validM<=validE;
//                           hilo_wenM<=hilo_wenE & validE
//  Commit: {HI,LO}<=alu_outM at edge iff validM & hilo_wenM & ~stallM
//   & ~flush_exceptionM. Exactly one commit per instruction: a stalled M
//   instruction commits on the first edge where stallM=0.
//  Commit latency: EX result visible on hi_o/lo_o 2 edges after it is on
//   alu_outE (E->M edge, M->commit edge), longer by number of stall cycles.
//  Forwarding (combinational): hiloE = (validM & hilo_wenM & ~flush_exceptionM)
//   ? alu_outM : {HI,LO}. EX consumers (mfhi/mflo/mthi/mtlo merge) use hiloE,
//   so back-to-back mult->mfhi and mtlo->mthi need no stall.
//  Full 2*DW image always written; partial-write merging (mthi keeps LO) is
//   done upstream in EX, never here.
//  Simultaneous stallM & flushM: stall wins, slot held.
//  flush_exceptionM with stallM: commit suppressed, slot cleared.
//  Reset mid-operation: pending M write discarded, HI/LO return to HILO_RST.
//  No X on outputs after reset; hilo_wenE ignored when validE=0.
// TESTING
//  T1 reset: rst=0 -> hi_o=lo_o=0, validM=0, hiloE=0; release, idle 3 cycles
//     -> all unchanged.
//  T2 mult commit: E validE=1,hilo_wenE=1,alu_outE=64'h0000_0001_FFFF_FFFE
//     -> next edge alu_outM matches, hiloE forwards it; following edge
//     hi_o=32'h1, lo_o=32'hFFFF_FFFE.
//  T3 exception kill: as T2 but flush_exceptionM=1 while in M -> hiloE reverts
//     to old {HI,LO} same cycle, hi_o/lo_o unchanged, validM=0 next edge.
//  T4 stall: instruction with alu_outE=64'hA5A5_0000_5A5A in M, stallM=1 for
//     3 cycles -> no commit, alu_outM held, hiloE=64'hA5A5_0000_5A5A;
//     stallM=0 -> single commit.
//  T5 stall+flush: stallM=1,flushM=1 together -> M slot held, no bubble;
//     stallM=0,flushM=1 -> validM=0, commit of held instr occurs same edge.
//  T6 back-to-back: mtlo image 64'h0000_0000_0000_0007 then mthi image
//     64'h0000_0009_0000_0007 on consecutive cycles -> final hi_o=9, lo_o=7.

Source files
------------

// File: rtl/hilo_commit_m.sv
// hilo_commit_m: M-stage slot register and architectural HI/LO owner.
// Commits HI/LO on exception-free departure from M and forwards the youngest {HI,LO} to EX.
module hilo_commit_m #(
    parameter int              DW       = 32,
    parameter logic [2*DW-1:0] HILO_RST = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallM,
    input  logic            flushM,
    input  logic            flush_exceptionM,
    input  logic            validE,
    input  logic            hilo_wenE,
    input  logic [2*DW-1:0] alu_outE,
    output logic [2*DW-1:0] alu_outM,
    output logic            validM,
    output logic            hilo_wenM,
    output logic [2*DW-1:0] hiloE,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o
);
    logic [2*DW-1:0] hilo;
    logic            pending;

    // A live HI/LO write sitting in M is the youngest value EX may observe.
    assign pending = validM & hilo_wenM & ~flush_exceptionM;
    assign hiloE   = pending ? alu_outM : hilo;
    assign hi_o    = hilo[2*DW-1:DW];
    assign lo_o    = hilo[DW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_outM  <= '0;
            validM    <= 1'b0;
            hilo_wenM <= 1'b0;
            hilo      <= HILO_RST;
        end else begin
            if (pending & ~stallM)
                hilo <= alu_outM;
            if (flush_exceptionM) begin
                validM    <= 1'b0;
                hilo_wenM <= 1'b0;
            end else if (!stallM) begin
                alu_outM  <= flushM ? '0 : alu_outE;
                validM    <= ~flushM & validE;
                hilo_wenM <= ~flushM & validE & hilo_wenE;
            end
        end
    end
endmodule

// File: tb/tb_hilo_commit_m.sv
// tb_hilo_commit_m: randomized and directed checks of hilo_commit_m against a
// slot/commit reference model.
module tb_hilo_commit_m;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallM = 1'b0, flushM = 1'b0, flush_exceptionM = 1'b0;
    logic        validE = 1'b0, hilo_wenE = 1'b0;
    logic [63:0] alu_outE = '0;
    logic [63:0] alu_outM, hiloE;
    logic        validM, hilo_wenM;
    logic [31:0] hi_o, lo_o;

    int vectors = 0;
    int errors  = 0;

    // reference state: the instruction occupying M and the committed pair
    logic        r_valid, r_wen;
    logic [63:0] r_data, r_hilo;

    hilo_commit_m dut (
        .clk(clk), .rst(rst), .stallM(stallM), .flushM(flushM),
        .flush_exceptionM(flush_exceptionM), .validE(validE), .hilo_wenE(hilo_wenE),
        .alu_outE(alu_outE), .alu_outM(alu_outM), .validM(validM),
        .hilo_wenM(hilo_wenM), .hiloE(hiloE), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        r_valid = 1'b0;
        r_wen   = 1'b0;
        r_data  = '0;
        r_hilo  = '0;
    endtask

    task automatic check_state();
        check("alu_outM", alu_outM, r_data);
        check("validM", {63'b0, validM}, {63'b0, r_valid});
        check("hilo_wenM", {63'b0, hilo_wenM}, {63'b0, r_wen});
        check("hi_o", {32'b0, hi_o}, {32'b0, r_hilo[63:32]});
        check("lo_o", {32'b0, lo_o}, {32'b0, r_hilo[31:0]});
    endtask

    // Apply one cycle of inputs (called just after a falling edge).
    task automatic step(input logic se, input logic fm, input logic fe,
                        input logic ve, input logic we, input logic [63:0] d);
        logic instr_writes;
        stallM = se; flushM = fm; flush_exceptionM = fe;
        validE = ve; hilo_wenE = we; alu_outE = d;
        #1;
        instr_writes = r_valid && r_wen;
        check("hiloE", hiloE, (instr_writes && !fe) ? r_data : r_hilo);
        @(posedge clk);
        if (instr_writes && !fe && !se) r_hilo = r_data;
        if (fe) begin
            r_valid = 1'b0;
            r_wen   = 1'b0;
        end else if (se) begin
        end else if (fm) begin
            r_valid = 1'b0;
            r_wen   = 1'b0;
            r_data  = '0;
        end else begin
            r_valid = ve;
            r_wen   = ve && we;
            r_data  = d;
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, '0);
    endtask

    initial begin
        model_reset();
        #2;
        check_state();
        check("hiloE_rst", hiloE, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) idle();

        // mult commit, two edges to architectural state
        step(0, 0, 0, 1, 1, 64'h0000_0001_FFFF_FFFE);
        check("T2_aluM", alu_outM, 64'h0000_0001_FFFF_FFFE);
        idle();
        check("T2_hi", {32'b0, hi_o}, 64'h1);
        check("T2_lo", {32'b0, lo_o}, 64'hFFFF_FFFE);

        // exception kills the commit
        step(0, 0, 0, 1, 1, 64'h1234_5678_9ABC_DEF0);
        step(0, 0, 1, 0, 0, '0);
        check("T3_hi", {32'b0, hi_o}, 64'h1);

        // stall holds, then a single commit
        step(0, 0, 0, 1, 1, 64'h0000_A5A5_0000_5A5A);
        repeat (3) step(1, 0, 0, 0, 0, '0);
        idle();
        idle();
        check("T4_lo", {32'b0, lo_o}, 64'h5A5A);

        // stall beats flush; release with flush still commits
        step(0, 0, 0, 1, 1, 64'h0000_0003_0000_0004);
        step(1, 1, 0, 1, 1, 64'hDEAD_BEEF_DEAD_BEEF);
        step(0, 1, 0, 1, 1, 64'hDEAD_BEEF_DEAD_BEEF);
        check("T5_hi", {32'b0, hi_o}, 64'h3);

        // stall with exception: no commit, slot cleared
        step(0, 0, 0, 1, 1, 64'h0000_00FF_0000_00FF);
        step(1, 0, 1, 0, 0, '0);
        idle();
        check("T5b_hi", {32'b0, hi_o}, 64'h3);

        // back-to-back mtlo/mthi
        step(0, 0, 0, 1, 1, 64'h0000_0000_0000_0007);
        step(0, 0, 0, 1, 1, 64'h0000_0009_0000_0007);
        idle();
        idle();
        check("T6_hi", {32'b0, hi_o}, 64'h9);
        check("T6_lo", {32'b0, lo_o}, 64'h7);

        // hilo_wenE without validE must not write
        step(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        idle();
        check("novalid_lo", {32'b0, lo_o}, 64'h7);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 6, {$urandom, $urandom});
            if (i == 300) begin
                step(0, 0, 0, 1, 1, 64'hCAFE_0000_0000_BABE);
                #2 rst = 1'b0;
                #1;
                model_reset();
                check_state();
                @(negedge clk);
                rst = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
